// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank: event indices driven by
// the pipeline and the read-map offsets that follow the last counter word.
package perf_pkg;

  // Bit positions in the event-pulse vector
  localparam int EVT_INST_FETCH = 0;
  localparam int EVT_MEM_RD     = 1;
  localparam int EVT_MEM_WR     = 2;
  localparam int EVT_BRANCH     = 3;
  localparam int EVT_JUMP       = 4;
  localparam int EVT_LOAD_STALL = 5;

  // Read addresses past the counter words, as offsets from NUM_CNT
  localparam int RD_CYC_HI = 0;
  localparam int RD_OVF    = 1;

endpackage

// File: rtl/perf_cnt_bank_if.sv
// Read channel of the counter bank: valid/ready request carrying an address,
// valid/ready response carrying one counter-width data word.
interface perf_cnt_bank_if #(
  parameter int NUM_CNT = 16,
  parameter int CNT_WD  = 32
);
  localparam int AW = $clog2(NUM_CNT + 2);

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [AW-1:0]     rd_addr;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [CNT_WD-1:0] rd_data;

  modport master (
    output rd_req_valid, rd_addr, rd_resp_ready,
    input  rd_req_ready, rd_resp_valid, rd_data
  );

  modport slave (
    input  rd_req_valid, rd_addr, rd_resp_ready,
    output rd_req_ready, rd_resp_valid, rd_data
  );
endinterface

// File: rtl/perf_cnt_slot.sv
// One programmable event counter: selects an event bit, counts when enabled
// and not frozen, wraps modulo 2^CNT_WD and keeps a sticky wrap flag.
// A configuration write reloads select/enable and zeroes the count, taking
// precedence over an event seen in the same cycle; clear beats both.
module perf_cnt_slot #(
  parameter int CNT_WD  = 32,
  parameter int NUM_EVT = 16,
  parameter int SEL_W   = $clog2(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clear,
  input  logic               freeze,
  input  logic               cfg_wr,
  input  logic [SEL_W-1:0]   cfg_evt_sel,
  input  logic               cfg_en,
  output logic [CNT_WD-1:0]  cnt,
  output logic               ovf
);

  logic [SEL_W-1:0]  sel_reg;
  logic              en_reg;
  logic [CNT_WD-1:0] cnt_reg;
  logic              ovf_reg;
  logic              inc;

  assign inc = en_reg & evt[sel_reg] & ~freeze;

  // Configuration fields update on any write, even one coincident with clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg <= '0;
      en_reg  <= 1'b0;
    end else if (cfg_wr) begin
      sel_reg <= cfg_evt_sel;
      en_reg  <= cfg_en;
    end
  end

  // Count with wrap; clear and reconfiguration both restart from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (clear || cfg_wr) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (&cnt_reg) ovf_reg <= 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/perf_cnt_bank.sv
// Performance-counter bank. Counter 0 is a free-running 2*CNT_WD-bit cycle
// counter; counters 1..NUM_CNT-1 are programmable event counters. Values are
// exported live on cnt_flat/ovf and through a one-deep registered read port.
// Optional build macro PERF_SNAPSHOT_EN adds shadow registers loaded by
// ctrl_snap; reads then return the shadow copy while cnt_flat stays live.
module perf_cnt_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 16,
  parameter int CNT_WD  = 32,
  parameter int NUM_EVT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_EVT-1:0]          evt,
  input  logic                        ctrl_clear,
  input  logic                        ctrl_freeze,
  input  logic                        ctrl_snap,
  input  logic                        cfg_wen,
  input  logic [$clog2(NUM_CNT)-1:0]  cfg_idx,
  input  logic [$clog2(NUM_EVT)-1:0]  cfg_evt_sel,
  input  logic                        cfg_en,
  perf_cnt_bank_if.slave              rd,
  output logic [NUM_CNT*CNT_WD-1:0]   cnt_flat,
  output logic [NUM_CNT-1:0]          ovf
);

  logic [CNT_WD-1:0]         cyc_lo_reg;
  logic [CNT_WD-1:0]         cyc_hi_reg;
  logic                      cyc_ovf_reg;
  logic [NUM_CNT*CNT_WD-1:0] src_flat;
  logic [CNT_WD-1:0]         src_hi;
  logic [NUM_CNT-1:0]        src_ovf;
  logic [CNT_WD-1:0]         rd_word;
  logic                      resp_valid_reg;
  logic [CNT_WD-1:0]         rd_data_reg;
  logic                      rd_accept;

  // Cycle counter: low-word wrap carries into the high word in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_lo_reg  <= '0;
      cyc_hi_reg  <= '0;
      cyc_ovf_reg <= 1'b0;
    end else if (ctrl_clear) begin
      cyc_lo_reg  <= '0;
      cyc_hi_reg  <= '0;
      cyc_ovf_reg <= 1'b0;
    end else if (!ctrl_freeze) begin
      cyc_lo_reg <= cyc_lo_reg + 1'b1;
      if (&cyc_lo_reg) begin
        cyc_hi_reg <= cyc_hi_reg + 1'b1;
        if (&cyc_hi_reg) cyc_ovf_reg <= 1'b1;
      end
    end
  end

  assign cnt_flat[0 +: CNT_WD] = cyc_lo_reg;
  assign ovf[0]                = cyc_ovf_reg;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_CNT; gi++) begin : g_slot
      logic cfg_hit;
      // Index 0 never matches, so writes aimed at the cycle counter are dropped
      assign cfg_hit = cfg_wen && (int'(cfg_idx) == gi);

      perf_cnt_slot #(
        .CNT_WD  (CNT_WD),
        .NUM_EVT (NUM_EVT)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .evt         (evt),
        .clear       (ctrl_clear),
        .freeze      (ctrl_freeze),
        .cfg_wr      (cfg_hit),
        .cfg_evt_sel (cfg_evt_sel),
        .cfg_en      (cfg_en),
        .cnt         (cnt_flat[gi*CNT_WD +: CNT_WD]),
        .ovf         (ovf[gi])
      );
    end
  endgenerate

`ifdef PERF_SNAPSHOT_EN
  logic [NUM_CNT*CNT_WD-1:0] snap_flat_reg;
  logic [CNT_WD-1:0]         snap_hi_reg;
  logic [NUM_CNT-1:0]        snap_ovf_reg;

  // Shadow copy samples register outputs, so a snap with clear keeps pre-clear values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_flat_reg <= '0;
      snap_hi_reg   <= '0;
      snap_ovf_reg  <= '0;
    end else if (ctrl_snap) begin
      snap_flat_reg <= cnt_flat;
      snap_hi_reg   <= cyc_hi_reg;
      snap_ovf_reg  <= ovf;
    end
  end

  assign src_flat = snap_flat_reg;
  assign src_hi   = snap_hi_reg;
  assign src_ovf  = snap_ovf_reg;
`else
  logic unused_snap;
  assign unused_snap = ctrl_snap;

  assign src_flat = cnt_flat;
  assign src_hi   = cyc_hi_reg;
  assign src_ovf  = ovf;
`endif

  // Read map: counter low words, then cycle high word, then ovf; above that zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(rd.rd_addr) == i) rd_word = src_flat[i*CNT_WD +: CNT_WD];
    end
    if (int'(rd.rd_addr) == NUM_CNT + RD_CYC_HI) rd_word = src_hi;
    if (int'(rd.rd_addr) == NUM_CNT + RD_OVF)    rd_word = CNT_WD'(src_ovf);
  end

  assign rd.rd_req_ready = ~resp_valid_reg | rd.rd_resp_ready;
  assign rd_accept       = rd.rd_req_valid & rd.rd_req_ready;

  // Single response register: loads on accept, holds data while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      rd_data_reg    <= '0;
    end else if (rd_accept) begin
      resp_valid_reg <= 1'b1;
      rd_data_reg    <= rd_word;
    end else if (rd.rd_resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign rd.rd_resp_valid = resp_valid_reg;
  assign rd.rd_data       = rd_data_reg;

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Self-checking bench for perf_cnt_bank. The DUT is built with NUM_CNT=8,
// CNT_WD=8 so that counter and cycle-word wraps are reached by real events
// in a short run (no forcing of internal state). Read map for this build:
// addr 0..7 counters, 8 cycle high word, 9 ovf, 10..15 zero.
// A behavioural model (full-width cycle count, per-counter event totals,
// arithmetic wrap) is stepped at every clock edge and compared with every
// output one time unit after the edge. Read data expected for an accept is
// the model value before that edge's update.
module tb_perf_cnt_bank;
  import perf_pkg::*;

  localparam int NC = 8;
  localparam int W  = 8;
  localparam int NE = 16;
  localparam int IW = $clog2(NC);
  localparam int SW = $clog2(NE);
  localparam int AW = $clog2(NC + 2);

  logic            clk = 1'b0;
  logic            rst;
  logic [NE-1:0]   evt;
  logic            ctrl_clear, ctrl_freeze, ctrl_snap;
  logic            cfg_wen;
  logic [IW-1:0]   cfg_idx;
  logic [SW-1:0]   cfg_evt_sel;
  logic            cfg_en;
  logic [NC*W-1:0] cnt_flat;
  logic [NC-1:0]   ovf;

  perf_cnt_bank_if #(.NUM_CNT(NC), .CNT_WD(W)) rd_if ();

  perf_cnt_bank #(.NUM_CNT(NC), .CNT_WD(W), .NUM_EVT(NE)) dut (
    .clk         (clk),
    .rst         (rst),
    .evt         (evt),
    .ctrl_clear  (ctrl_clear),
    .ctrl_freeze (ctrl_freeze),
    .ctrl_snap   (ctrl_snap),
    .cfg_wen     (cfg_wen),
    .cfg_idx     (cfg_idx),
    .cfg_evt_sel (cfg_evt_sel),
    .cfg_en      (cfg_en),
    .rd          (rd_if.slave),
    .cnt_flat    (cnt_flat),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint unsigned m_cyc;
  longint unsigned m_cnt [NC];
  bit              m_ovf [NC];
  int              m_sel [NC];
  bit              m_en  [NC];
  bit              m_rv;
  longint unsigned m_rd;
`ifdef PERF_SNAPSHOT_EN
  longint unsigned s_cyc;
  longint unsigned s_cnt [NC];
  bit              s_ovf [NC];
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_cyc = 0; m_rv = 0; m_rd = 0;
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_sel[i] = 0; m_en[i] = 0;
    end
`ifdef PERF_SNAPSHOT_EN
    s_cyc = 0;
    for (int i = 0; i < NC; i++) begin s_cnt[i] = 0; s_ovf[i] = 0; end
`endif
  endtask

  function automatic longint unsigned model_read(int a);
    longint unsigned c0;
    longint unsigned cn [NC];
    bit              ov [NC];
    longint unsigned r = 0;
`ifdef PERF_SNAPSHOT_EN
    c0 = s_cyc; cn = s_cnt; ov = s_ovf;
`else
    c0 = m_cyc; cn = m_cnt; ov = m_ovf;
`endif
    if (a == 0)                   r = c0 % (64'd1 << W);
    else if (a < NC)              r = cn[a];
    else if (a == NC + RD_CYC_HI) r = c0 >> W;
    else if (a == NC + RD_OVF) begin
      for (int i = 0; i < NC; i++) if (ov[i]) r = r + (64'd1 << i);
      r = r % (64'd1 << W);
    end
    return r;
  endfunction

  task automatic model_update(bit acc, longint unsigned rdv);
`ifdef PERF_SNAPSHOT_EN
    if (ctrl_snap) begin s_cyc = m_cyc; s_cnt = m_cnt; s_ovf = m_ovf; end
`endif
    if (ctrl_clear) begin
      m_cyc = 0;
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    end else begin
      if (!ctrl_freeze) begin
        m_cyc++;
        if (m_cyc == (64'd1 << (2 * W))) begin m_cyc = 0; m_ovf[0] = 1; end
      end
      for (int i = 1; i < NC; i++) begin
        if (cfg_wen && int'(cfg_idx) == i) begin
          m_cnt[i] = 0; m_ovf[i] = 0;
        end else if (m_en[i] && evt[m_sel[i]] && !ctrl_freeze) begin
          m_cnt[i]++;
          if (m_cnt[i] == (64'd1 << W)) begin m_cnt[i] = 0; m_ovf[i] = 1; end
        end
      end
    end
    if (cfg_wen && int'(cfg_idx) >= 1 && int'(cfg_idx) < NC) begin
      m_sel[int'(cfg_idx)] = int'(cfg_evt_sel);
      m_en[int'(cfg_idx)]  = cfg_en;
    end
    if (acc) begin m_rv = 1; m_rd = rdv; end
    else if (rd_if.rd_resp_ready) m_rv = 0;
  endtask

  task automatic check_all();
    logic [63:0] ef;
    logic [63:0] eo;
    ef = '0; eo = '0;
    for (int i = 0; i < NC; i++) begin
      ef[i*W +: W] = (i == 0) ? W'(m_cyc) : W'(m_cnt[i]);
      eo[i]        = m_ovf[i];
    end
    chk("cnt_flat", 64'(cnt_flat), ef);
    chk("ovf", 64'(ovf), eo);
    chk("resp_valid", 64'(rd_if.rd_resp_valid), 64'(m_rv));
    chk("req_ready", 64'(rd_if.rd_req_ready), 64'(!m_rv || rd_if.rd_resp_ready));
    if (m_rv) chk("rd_data", 64'(rd_if.rd_data), m_rd);
  endtask

  // One clock: predict read data before the edge, step the model, check after
  task automatic tick();
    bit acc;
    longint unsigned rdv;
    acc = rd_if.rd_req_valid && (!m_rv || rd_if.rd_resp_ready);
    rdv = model_read(int'(rd_if.rd_addr));
    @(posedge clk);
    model_update(acc, rdv);
    #1;
    check_all();
  endtask

  task automatic pulse(int bitpos, int n);
    for (int k = 0; k < n; k++) begin
      evt = '0; evt[bitpos] = 1'b1;
      tick();
    end
    evt = '0;
  endtask

  task automatic do_cfg(int idx, int sel, bit en);
    cfg_wen = 1'b1; cfg_idx = IW'(idx); cfg_evt_sel = SW'(sel); cfg_en = en;
    tick();
    cfg_wen = 1'b0;
  endtask

  // Single read; response is visible when this returns
  task automatic read1(int a);
    rd_if.rd_req_valid = 1'b1; rd_if.rd_addr = AW'(a);
    tick();
    rd_if.rd_req_valid = 1'b0;
    $display("read addr=%0d data=%0h", a, rd_if.rd_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; evt = '0; ctrl_clear = 0; ctrl_freeze = 0; ctrl_snap = 0;
    cfg_wen = 0; cfg_idx = '0; cfg_evt_sel = '0; cfg_en = 0;
    rd_if.rd_req_valid = 0; rd_if.rd_addr = '0; rd_if.rd_resp_ready = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("reset_rd_data", 64'(rd_if.rd_data), 64'd0);
    rst = 1'b0;

    // Ten idle cycles; the read accepted on the 11th edge returns 10
    repeat (10) tick();
    read1(0);
    chk("cyc_after_10", 64'(rd_if.rd_data), 64'd10);
    for (int a = 1; a < NC; a++) begin
      read1(a);
      chk("idle_cnt_zero", 64'(rd_if.rd_data), 64'd0);
    end
    read1(NC + RD_OVF);
    chk("idle_ovf_zero", 64'(rd_if.rd_data), 64'd0);
    read1(NC + RD_OVF + 3);
    chk("unmapped_zero", 64'(rd_if.rd_data), 64'd0);

    // Counter 3 watches MEM_WR; MEM_RD toggles alongside and must be ignored
    do_cfg(3, EVT_MEM_WR, 1'b1);
    for (int k = 0; k < 10; k++) begin
      evt = '0;
      evt[EVT_MEM_WR] = (k % 2 == 0);
      evt[EVT_MEM_RD] = (k % 3 != 0);
      tick();
    end
    evt = '0;
    chk("cnt3_five", 64'(cnt_flat[3*W +: W]), 64'd5);
    chk("cnt4_zero", 64'(cnt_flat[4*W +: W]), 64'd0);
    read1(3);
    chk("rd_cnt3_five", 64'(rd_if.rd_data), 64'd5);
    do_cfg(0, EVT_JUMP, 1'b1);
    pulse(EVT_MEM_WR, 1);
    chk("cfg_idx0_ignored", 64'(cnt_flat[3*W +: W]), 64'd6);

    // Drive counter 3 to all-ones minus one, then wrap it
    pulse(EVT_MEM_WR, 248);
    chk("cnt3_fe", 64'(cnt_flat[3*W +: W]), 64'hFE);
    pulse(EVT_MEM_WR, 2);
    chk("cnt3_wrap", 64'(cnt_flat[3*W +: W]), 64'd0);
    chk("ovf3_set", 64'(ovf[3]), 64'd1);
    ctrl_clear = 1'b1; tick(); ctrl_clear = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);
    chk("cyc_cleared", 64'(cnt_flat[0 +: W]), 64'd0);

    // Cycle low word wrap carries into the high word
    repeat (255) tick();
    chk("cyc_lo_ff", 64'(cnt_flat[0 +: W]), 64'hFF);
    tick();
    chk("cyc_lo_wrap", 64'(cnt_flat[0 +: W]), 64'd0);
    read1(NC + RD_CYC_HI);
    chk("cyc_hi_one", 64'(rd_if.rd_data), 64'd1);

    // Backpressure: response held while sink stalls, then four back-to-back reads
    tick();
    rd_if.rd_resp_ready = 1'b0;
    rd_if.rd_req_valid = 1'b1; rd_if.rd_addr = AW'(0);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_req_ready", 64'(rd_if.rd_req_ready), 64'd0);
      chk("stall_hold_data", 64'(rd_if.rd_data), m_rd);
    end
    rd_if.rd_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_if.rd_addr = AW'(k + 1);
      tick();
      chk("b2b_valid", 64'(rd_if.rd_resp_valid), 64'd1);
      $display("b2b read addr=%0d data=%0h", k + 1, rd_if.rd_data);
    end
    rd_if.rd_req_valid = 1'b0;
    tick();
    chk("b2b_drained", 64'(rd_if.rd_resp_valid), 64'd0);

    // Snapshot at 7 events, four more events, then read counter 3
    do_cfg(3, EVT_MEM_WR, 1'b1);
    pulse(EVT_MEM_WR, 7);
    ctrl_snap = 1'b1; tick(); ctrl_snap = 1'b0;
    pulse(EVT_MEM_WR, 4);
    chk("live_cnt3_11", 64'(cnt_flat[3*W +: W]), 64'd11);
    read1(3);
`ifdef PERF_SNAPSHOT_EN
    chk("snap_rd_cnt3", 64'(rd_if.rd_data), 64'd7);
`else
    chk("live_rd_cnt3", 64'(rd_if.rd_data), 64'd11);
`endif

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      evt         = NE'($urandom | $urandom);
      ctrl_clear  = ($urandom_range(0, 39) == 0);
      ctrl_freeze = ($urandom_range(0, 7) == 0);
      ctrl_snap   = ($urandom_range(0, 15) == 0);
      cfg_wen     = ($urandom_range(0, 9) == 0);
      cfg_idx     = IW'($urandom_range(0, NC - 1));
      cfg_evt_sel = SW'($urandom_range(0, 5));
      cfg_en      = ($urandom_range(0, 3) != 0);
      rd_if.rd_req_valid  = 1'($urandom_range(0, 1));
      rd_if.rd_addr       = AW'($urandom_range(0, 15));
      rd_if.rd_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (k % 50 == 0)
        $display("rand step=%0d resp_valid=%0b data=%0h", k, rd_if.rd_resp_valid, rd_if.rd_data);
    end
    evt = '0; ctrl_clear = 0; ctrl_freeze = 0; ctrl_snap = 0; cfg_wen = 0;

    // Reset between edges drops a stalled response
    rd_if.rd_resp_ready = 1'b0;
    rd_if.rd_req_valid = 1'b0;
    tick();
    rd_if.rd_resp_ready = 1'b1;
    tick();
    rd_if.rd_resp_ready = 1'b0;
    rd_if.rd_req_valid = 1'b1; rd_if.rd_addr = AW'(2);
    tick();
    rd_if.rd_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    reset_model();
    chk("rst_drop_valid", 64'(rd_if.rd_resp_valid), 64'd0);
    chk("rst_drop_data", 64'(rd_if.rd_data), 64'd0);
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    rd_if.rd_resp_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_cyc", 64'(cnt_flat[0 +: W]), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/perf_cnt_bank.md
Name: perf_cnt_bank

Overview:
- Parametrised performance-counter bank that replaces the fixed per-event counters in the CPU top.
- Counter 0 is a hard-wired 2*CNT_WD-bit cycle counter.
- Counters 1..NUM_CNT-1 each count one programmable event from an event-pulse vector driven by the pipeline stages (fetch handshake, mem read/write, branch, jump, ...).
- Values are exported flat for the cpu_perf_cnt_* outputs and through a valid/ready read channel.

Parameters:
- NUM_CNT, 16, number of counters including the cycle counter (2..32)
- CNT_WD, 32, width of each counter and of the read data
- NUM_EVT, 16, width of the event-pulse vector (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- evt  in  NUM_EVT  one-cycle event pulses; bit k high = event k occurred this cycle
- ctrl_clear  in  1  pulse: zero all counters and overflow bits
- ctrl_freeze  in  1  level: hold all counters
- ctrl_snap  in  1  pulse: capture all counters into shadow registers
- cfg_wen  in  1  configuration write strobe
- cfg_idx  in  $clog2(NUM_CNT)  counter being configured
- cfg_evt_sel  in  $clog2(NUM_EVT)  event index for that counter
- cfg_en  in  1  enable for that counter
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request ready
- rd_addr  in  $clog2(NUM_CNT+2)  read address
- rd_resp_valid  out  1  read response valid
- rd_resp_ready  in  1  read response ready
- rd_data  out  CNT_WD  read response data
- cnt_flat  out  NUM_CNT*CNT_WD  live low words; counter i at [i*CNT_WD +: CNT_WD]
- ovf  out  NUM_CNT  sticky wrap flags

Behaviour:
- Reset (async, rst=1): all counters, cycle high word, shadows, ovf, evt_sel and en = 0; rd_resp_valid=0; rd_data=0.
- Counter 0:
  - increments by 1 every cycle unless ctrl_freeze.
  - Low word wrap from all-ones carries +1 into the high word the same cycle.
  - ovf[0] sets only when the high word wraps.
- Counter i>0:
  - increments by 1 in cycle t iff en[i] & evt[evt_sel[i]] & !ctrl_freeze.
  - Wraps modulo 2^CNT_WD; ovf[i] sets on wrap and stays set until cleared.
- Priority per cycle: ctrl_clear > cfg write > increment.
  - ctrl_clear: every counter, high word and ovf bit reads 0 next cycle.
  - cfg_wen with cfg_idx>0: next cycle evt_sel/en take the new values and that counter and its ovf bit are zeroed; an event in the write cycle is not counted.
  - cfg_wen with cfg_idx=0 or cfg_idx>=NUM_CNT: ignored.
  - cfg_wen coincident with ctrl_clear: config fields still update.
- ctrl_freeze has no effect on clear, config or reads.
- Read map:
  - addr 0..NUM_CNT-1: counter low word.
  - addr NUM_CNT: cycle high word.
  - addr NUM_CNT+1: ovf, zero-extended to CNT_WD.
  - Higher addresses: 0.
- Read channel: single output register, one-cycle latency.
  - rd_req_ready = !rd_resp_valid | rd_resp_ready.
  - Request accepted when rd_req_valid & rd_req_ready; rd_resp_valid asserts the next cycle with rd_data.
  - rd_data stays stable while rd_resp_valid & !rd_resp_ready.
  - Back-to-back reads sustain one per cycle when rd_resp_ready=1.
  - Read data reflects register state at the accept edge, i.e. before that cycle's update.
- Reset mid-read drops the pending response.

Optional Feature:
- Macro PERF_SNAPSHOT_EN.
- Defined:
  - ctrl_snap copies all counters, the high word and ovf into shadows atomically.
  - Read addresses return shadow values; cnt_flat stays live.
  - ctrl_snap coincident with ctrl_clear captures pre-clear values.
- Undefined: no shadow registers, ctrl_snap ignored, reads return live values.

Decomposition:
- Shared package perf_pkg:
  - event index constants: EVT_INST_FETCH=0, EVT_MEM_RD=1, EVT_MEM_WR=2, EVT_BRANCH=3, EVT_JUMP=4, EVT_LOAD_STALL=5.
  - read-map offset constants RD_CYC_HI, RD_OVF.
- One natural sub-module perf_cnt_slot: one programmable counter with select, enable, clear, wrap and ovf. Instantiated NUM_CNT-1 times via generate.
- Cycle counter, read channel and snapshot stay in the top.

Test Plan:
- Reset, then run 10 idle cycles with freeze=0 -> rd_addr 0 returns 10 (±accept-cycle offset documented in bench); counters 1..15 read 0; rd_addr 17 returns 0.
- cfg idx=3 sel=2 en=1; pulse evt[2] 5 times with evt[1] toggling -> counter 3 = 5, counter 4 = 0; cfg idx=0 write has no effect.
- Preload via bench force: counter 3 = 0xFFFFFFFE, two evt[2] pulses -> counter 3 = 0, ovf[3]=1; ctrl_clear -> ovf=0 next cycle.
- Cycle low word forced to 0xFFFFFFFF -> next cycle low=0, rd_addr 16 returns 1.
- Hold rd_resp_ready=0 for 3 cycles after a request -> rd_req_ready=0, rd_data stable; then ready=1 with 4 back-to-back requests -> 4 responses in 4 consecutive cycles.
- PERF_SNAPSHOT_EN: snap at counter 3 = 7, 4 more events -> read returns 7, cnt_flat shows 11; with macro undefined the read returns 11.
